// File: rtl/divider_pkg.sv
// Shared definitions for the divider: datapath width, operation encoding,
// step counts and a 32->XLEN sign-extension helper.
`ifndef XLEN
`define XLEN 64
`endif

package divider_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } op_t;

  localparam int STEPS_FULL = 64;
  localparam int STEPS_WORD = 32;

  function automatic logic [`XLEN-1:0] sext32(input logic [31:0] v);
    return {{(`XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/divider.sv
// Iterative radix-2 restoring divider: DIV/DIVU/REM/REMU and their W forms.
// Optional macro DIVIDER_EARLY_OUT_EN: divide-by-zero and signed overflow
// skip the iteration and finish one cycle after acceptance.
import divider_pkg::*;

module divider (
  input  logic              clk,
  input  logic              reset_n,
  input  op_t               op,
  input  logic              is_word_op,
  input  logic [`XLEN-1:0]  a,
  input  logic [`XLEN-1:0]  b,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [`XLEN-1:0]  result,
  output logic              valid_out,
  input  logic              ready_in
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] CNT_FULL = 6'(STEPS_FULL - 1);
  localparam logic [5:0] CNT_WORD = 6'(STEPS_WORD - 1);

  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             last_q, last_d;      // all steps done, finalize next
  logic [`XLEN-1:0] quot_q, quot_d;      // dividend shifts out, quotient shifts in
  logic [`XLEN-1:0] rem_q, rem_d;        // partial remainder
  logic [`XLEN-1:0] dvsr_q, dvsr_d;      // divisor magnitude
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             rsel_q, rsel_d;      // 1: return remainder
  logic             word_q, word_d;
  logic             spec_q, spec_d;      // div-by-zero or signed overflow
  logic [`XLEN-1:0] spec_val_q, spec_val_d;
  logic [`XLEN-1:0] result_q, result_d;

  // Operand preparation at acceptance
  logic             signed_op, a_neg, b_neg, div0, ovf, is_rem;
  logic [`XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  // Iteration step and finalize
  logic [`XLEN:0]   shifted, diff;
  logic [`XLEN-1:0] q_fix, r_fix, fin;
  logic             early;

  assign ready_out = (state_q == S_IDLE);
  assign valid_out = (state_q == S_DONE);
  assign result    = result_q;

  // Next-state, operand conditioning, divide step and result selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    rsel_d     = rsel_q;
    word_d     = word_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;

    signed_op = (op == DIV) || (op == REM);
    is_rem    = (op == REM) || (op == REMU);
    if (is_word_op) begin
      a_ext = signed_op ? sext32(a[31:0]) : {32'b0, a[31:0]};
      b_ext = signed_op ? sext32(b[31:0]) : {32'b0, b[31:0]};
    end else begin
      a_ext = a;
      b_ext = b;
    end
    a_neg = signed_op && a_ext[`XLEN-1];
    b_neg = signed_op && b_ext[`XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    div0  = (b_ext == '0);
    ovf   = signed_op && (b_ext == '1) &&
            (a_ext == (is_word_op ? sext32(32'h8000_0000) : {1'b1, {(`XLEN-1){1'b0}}}));

    // Restoring step: shift in next dividend bit, subtract if it fits
    shifted = {rem_q, quot_q[`XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};

    q_fix = qneg_q ? -quot_q : quot_q;
    r_fix = rneg_q ? -rem_q : rem_q;
    fin   = spec_q ? spec_val_q : (rsel_q ? r_fix : q_fix);

`ifdef DIVIDER_EARLY_OUT_EN
    early = spec_q;
`else
    early = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          // W ops park the 32-bit dividend in the top half so 32 steps suffice
          quot_d     = is_word_op ? {a_mag[31:0], 32'b0} : a_mag;
          rem_d      = '0;
          dvsr_d     = b_mag;
          qneg_d     = a_neg ^ b_neg;
          rneg_d     = a_neg;
          rsel_d     = is_rem;
          word_d     = is_word_op;
          spec_d     = div0 || ovf;
          spec_val_d = div0 ? (is_rem ? a_ext : '1) : (is_rem ? '0 : a_ext);
          cnt_d      = is_word_op ? CNT_WORD : CNT_FULL;
          last_d     = 1'b0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (last_q || early) begin
          result_d = word_q ? sext32(fin[31:0]) : fin;
          cnt_d    = '0;
          last_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          if (!diff[`XLEN]) begin
            rem_d  = diff[`XLEN-1:0];
            quot_d = {quot_q[`XLEN-2:0], 1'b1};
          end else begin
            rem_d  = shifted[`XLEN-1:0];
            quot_d = {quot_q[`XLEN-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      S_DONE: begin
        if (ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      rsel_q     <= 1'b0;
      word_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      rsel_q     <= rsel_d;
      word_q     <= word_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: hand-computed vectors, latency and
// handshake checks, mid-operation reset.
import divider_pkg::*;

module tb_divider;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  op_t         op = DIV;
  logic        is_word_op = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [63:0] result;
  logic        valid_out;
  logic        ready_in = 1'b0;

  int checks = 0;
  int fails  = 0;

`ifdef DIVIDER_EARLY_OUT_EN
  localparam int SPEC_LAT   = 1;
  localparam int SPEC_LAT_W = 1;
`else
  localparam int SPEC_LAT   = 65;
  localparam int SPEC_LAT_W = 33;
`endif

  divider dut (
    .clk(clk), .reset_n(reset_n), .op(op), .is_word_op(is_word_op),
    .a(a), .b(b), .valid_in(valid_in), .ready_out(ready_out),
    .result(result), .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency, hold DONE for 'hold' cycles, hand off
  task automatic do_op(input op_t o, input logic w, input logic [63:0] aa,
                       input logic [63:0] bb, input logic [63:0] exp,
                       input int exp_lat, input int hold, input string tag);
    int lat;
    @(negedge clk);
    chk({63'b0, ready_out}, 64'd1, {tag, "_ready"});
    op = o; is_word_op = w; a = aa; b = bb; valid_in = 1'b1; ready_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    a = 64'hDEAD_BEEF_0BAD_F00D; b = 64'h0123_4567_89AB_CDEF; op = REMU;
    lat = 0;
    while (!valid_out && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk(64'(lat), 64'(exp_lat), {tag, "_latency"});
    chk(result, exp, {tag, "_result"});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({62'b0, valid_out, ready_out}, 64'd2, {tag, "_hold_flags"});
      chk(result, exp, {tag, "_hold_result"});
    end
    ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_in = 1'b0;
    chk({62'b0, valid_out, ready_out}, 64'd1, {tag, "_handoff"});
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({62'b0, valid_out, ready_out}, 64'd1, "reset_flags");
    chk(result, 64'd0, "reset_result");
    reset_n = 1'b1;

    // Signed truncation and remainder sign
    do_op(DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 10, "div_m7_2");
    do_op(REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, "rem_m7_2");
    do_op(DIV,  1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0, "div_7_m2");
    do_op(REM,  1'b0, 64'd7, -64'sd2, 64'd1, 65, 0, "rem_7_m2");
    // Unsigned
    do_op(DIVU, 1'b0, 64'd1000, 64'd7, 64'd142, 65, 0, "divu_1000_7");
    do_op(REMU, 1'b0, 64'd1000, 64'd7, 64'd6, 65, 0, "remu_1000_7");
    do_op(DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, "divu_max_1");
    // Divide by zero
    do_op(DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SPEC_LAT, 0, "divu_by0");
    do_op(REMU, 1'b0, 64'd100, 64'd0, 64'd100, SPEC_LAT, 0, "remu_by0");
    do_op(DIV,  1'b0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SPEC_LAT, 0, "div_neg_by0");
    // Signed overflow
    do_op(DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, SPEC_LAT, 0, "div_ovf");
    do_op(REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'd0, SPEC_LAT, 0, "rem_ovf");
    // W variants: upper operand bits ignored, result sign-extended
    do_op(DIVU, 1'b1, 64'h1234_5678_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 0, "divuw_sext");
    do_op(DIV,  1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'h5555_5555_0000_0002,
          64'hFFFF_FFFF_FFFF_FFFD, 33, 0, "divw_m7_2");
    do_op(REM,  1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'h5555_5555_0000_0002,
          64'hFFFF_FFFF_FFFF_FFFF, 33, 0, "remw_m7_2");
    do_op(REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_0000_0000_0010, 64'd15, 33, 0, "remuw_f");
    do_op(DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, SPEC_LAT_W, 0, "divw_ovf");
    do_op(DIVU, 1'b1, 64'd5, 64'h1234_5678_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          SPEC_LAT_W, 0, "divuw_by0");

    // Reset during CALC aborts the operation
    @(negedge clk);
    op = DIV; is_word_op = 1'b0; a = 64'd123456; b = 64'd7; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    chk({62'b0, valid_out, ready_out}, 64'd0, "calc_busy");
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({62'b0, valid_out, ready_out}, 64'd1, "abort_flags");
    chk(result, 64'd0, "abort_result");
    reset_n = 1'b1;
    do_op(DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
